data_mem_responder: RTL



---
 rtl/mem_pkg.sv | 13 +
 rtl/lsu_lane_align.sv | 34 +++
 rtl/data_mem_responder.sv | 69 ++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, FSM states and response record for data_mem_responder.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane merge for stores, lane extract/extend for loads, misalign/illegal flag.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        bad
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        legal, misaligned;
  assign b = old_word[{lane, 3'b000} +: 8];
  assign h = old_word[{lane[1], 4'b0000} +: 16];
  assign legal = we ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W)
                    : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                       funct3 == F3_BU || funct3 == F3_HU);
  assign misaligned = (funct3[1:0] == 2'b01 && lane[0]) || (funct3[1:0] == 2'b10 && lane != 2'b00);
  assign bad = !legal || misaligned;
  always_comb begin
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h} : old_word;
    store_word = old_word;
    if (funct3 == F3_B) store_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H) store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else store_word = wdata;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised RV32I data memory answering one load/store at a time.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q, wdata_q;
  resp_t             resp;
  logic [31:0]       mem [2**ADDR_W] = '{default: '0};
  logic [ADDR_W-1:0] idx;
  logic [31:0]       store_word, load_data;
  logic              bad, err, fire;
  assign idx = addr_q[ADDR_W+1:2];
  assign err = bad || (|addr_q[31:ADDR_W+2]);
  assign fire = state == BUSY && cnt == 4'd0;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = resp.rdata;
  assign resp_err = resp.err;
  lsu_lane_align u_align (
    .we(we_q), .funct3(f3_q), .lane(addr_q[1:0]), .wdata(wdata_q),
    .old_word(mem[idx]), .store_word(store_word), .load_data(load_data), .bad(bad)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          cnt <= 4'(WAIT_CYCLES);
          state <= BUSY;
        end
        BUSY: if (!fire) cnt <= cnt - 4'd1;
        else begin
          resp <= '{rdata: (err || we_q) ? 32'd0 : load_data, err: err};
          state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // reset wins over a store whose commit edge coincides with it
  always_ff @(posedge clk) if (!reset && fire && we_q && !err) mem[idx] <= store_word;
endmodule
